// File: rtl/alu_bitop_seq_if.sv
// Request/response handshake between the instruction decoder and the bit-op sequencer.
interface alu_bitop_seq_if;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [2:0] req_bit;
   logic [7:0] req_data;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic       resp_zero;

   modport master (
      output req_valid, req_op, req_bit, req_data,
      input  req_ready, resp_valid, resp_data, resp_zero
   );

   modport slave (
      input  req_valid, req_op, req_bit, req_data,
      output req_ready, resp_valid, resp_data, resp_zero
   );
endinterface

// File: rtl/alu_bitop_seq.sv
// Sequencer for CB-prefix BIT/RES/SET: drives the shared ALU through bit select, operand load, result.
// Optional ALU_SEQ_CARRY_CHECK_EN builds a sticky carry-check error flag; otherwise err is tied low.
//
// state | meaning
// IDLE  | ALU released, idle word driven, ready for a request
// PH0   | bit select driven onto bus, loaded into B
// PH1   | operand + function controls, loaded into A
// PH2   | result on bus; result and zero captured
// RESP  | one-cycle response strobe
module alu_bitop_seq (
   input  logic        clk,
   input  logic        reset_n,
   alu_bitop_seq_if.slave bus,
   output logic        err,
   output logic        alu_busy,
   output logic [2:0]  alu_bs,
   output logic [7:0]  alu_op,
   output logic [1:0]  alu_oe,
   output logic        alu_la,
   output logic        alu_lb,
   output logic [1:0]  alu_sh,
   output logic        alu_r,
   output logic        alu_s,
   output logic        alu_v,
   output logic        alu_ne,
   output logic        alu_ci,
   output logic        alu_l,
   output logic        alu_h,
   input  logic [7:0]  alu_result,
   input  logic        alu_zero,
   input  logic        alu_carry
);

   localparam logic [1:0] IDLE_OE = 2'd0;
   localparam logic [1:0] BS_OE   = 2'd1;
   localparam logic [1:0] SH_OE   = 2'd2;
   localparam logic [1:0] RES_OE  = 2'd3;
   localparam logic       NO_LD   = 1'b0;
   localparam logic       BUS_LD  = 1'b1;
   localparam logic [1:0] NO_SH   = 2'd0;
   localparam logic [1:0] OP_RES  = 2'd1;
   localparam logic [1:0] OP_SET  = 2'd2;

   typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, RESP} state_t;

   state_t     state, state_nx;
   logic [1:0] op_q;
   logic [7:0] data_q;
   logic       accept;
   logic       fn_r, fn_s, fn_v;

   logic [2:0] nx_bs;
   logic [7:0] nx_op;
   logic [1:0] nx_oe, nx_sh;
   logic       nx_la, nx_lb, nx_r, nx_s, nx_v, nx_ne, nx_ci, nx_l, nx_h;

   assign accept = bus.req_valid && bus.req_ready;

   // reserved opcode falls through to BIT
   assign fn_r = (op_q == OP_SET);
   assign fn_s = (op_q == OP_RES);
   assign fn_v = !(fn_r || fn_s);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = PH0;
         PH0:     state_nx = PH1;
         PH1:     state_nx = PH2;
         PH2:     state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ALU word for the upcoming state, so every control line leaves a flop
   always_comb begin
      nx_bs = 3'd0;
      nx_op = 8'd0;
      nx_oe = IDLE_OE;
      nx_la = NO_LD;
      nx_lb = NO_LD;
      nx_sh = NO_SH;
      nx_r  = 1'b0;
      nx_s  = 1'b0;
      nx_v  = 1'b0;
      nx_ne = 1'b0;
      nx_ci = 1'b0;
      nx_l  = 1'b0;
      nx_h  = 1'b0;
      case (state_nx)
         PH0: begin
            nx_bs = bus.req_bit;
            nx_oe = BS_OE;
            nx_lb = BUS_LD;
         end
         PH1: begin
            nx_op = data_q;
            nx_oe = SH_OE;
            nx_la = BUS_LD;
            nx_r  = fn_r;
            nx_s  = fn_s;
            nx_v  = fn_v;
            nx_ne = 1'b1;
            nx_ci = 1'b1;
            nx_l  = 1'b1;
         end
         PH2: begin
            nx_oe = RES_OE;
            nx_r  = fn_r;
            nx_s  = fn_s;
            nx_v  = fn_v;
            nx_ne = 1'b1;
            nx_ci = 1'b1;
            nx_h  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         op_q           <= 2'd0;
         data_q         <= 8'd0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_data  <= 8'd0;
         bus.resp_zero  <= 1'b0;
         alu_busy       <= 1'b0;
      end else begin
         state          <= state_nx;
         bus.req_ready  <= (state_nx == IDLE);
         bus.resp_valid <= (state_nx == RESP);
         alu_busy       <= (state_nx == PH0) || (state_nx == PH1) || (state_nx == PH2);
         if (accept) begin
            op_q   <= bus.req_op;
            data_q <= bus.req_data;
         end
         if (state == PH2) begin
            bus.resp_data <= alu_result;
            bus.resp_zero <= alu_zero;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         alu_bs <= 3'd0;
         alu_op <= 8'd0;
         alu_oe <= IDLE_OE;
         alu_la <= NO_LD;
         alu_lb <= NO_LD;
         alu_sh <= NO_SH;
         alu_r  <= 1'b0;
         alu_s  <= 1'b0;
         alu_v  <= 1'b0;
         alu_ne <= 1'b0;
         alu_ci <= 1'b0;
         alu_l  <= 1'b0;
         alu_h  <= 1'b0;
      end else begin
         alu_bs <= nx_bs;
         alu_op <= nx_op;
         alu_oe <= nx_oe;
         alu_la <= nx_la;
         alu_lb <= nx_lb;
         alu_sh <= nx_sh;
         alu_r  <= nx_r;
         alu_s  <= nx_s;
         alu_v  <= nx_v;
         alu_ne <= nx_ne;
         alu_ci <= nx_ci;
         alu_l  <= nx_l;
         alu_h  <= nx_h;
      end
   end

`ifdef ALU_SEQ_CARRY_CHECK_EN
   always_ff @(posedge clk) begin
      if (!reset_n)
         err <= 1'b0;
      else if (((state == PH1) || (state == PH2)) && !alu_carry)
         err <= 1'b1;
   end
`else
   logic unused_carry;
   assign unused_carry = alu_carry;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_bitop_seq.sv
// Scoreboard bench for alu_bitop_seq with a small behavioural ALU driven by the sequencer's controls.
module tb_alu_bitop_seq;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       err, alu_busy;
   logic [2:0] alu_bs;
   logic [7:0] alu_op;
   logic [1:0] alu_oe, alu_sh;
   logic       alu_la, alu_lb, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
   logic [7:0] alu_result;
   logic       alu_zero, alu_carry;
   logic       force_nc = 1'b0;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   typedef struct {
      logic [7:0] d;
      logic       z;
      int         acc;
   } exp_t;
   exp_t sb[$];

   alu_bitop_seq_if bus ();

   alu_bitop_seq dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .err(err), .alu_busy(alu_busy),
      .alu_bs(alu_bs), .alu_op(alu_op), .alu_oe(alu_oe), .alu_la(alu_la), .alu_lb(alu_lb),
      .alu_sh(alu_sh), .alu_r(alu_r), .alu_s(alu_s), .alu_v(alu_v), .alu_ne(alu_ne),
      .alu_ci(alu_ci), .alu_l(alu_l), .alu_h(alu_h),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural ALU: B loads the bit select, A loads operand and function
   logic [2:0] m_bsel;
   logic [7:0] m_opnd;
   logic [2:0] m_fn;
   logic [7:0] m_mask;
   always @(posedge clk) begin
      if (alu_oe == 2'd1 && alu_lb) m_bsel <= alu_bs;
      if (alu_oe == 2'd2 && alu_la) begin
         m_opnd <= alu_op;
         m_fn   <= {alu_r, alu_s, alu_v};
      end
   end
   always_comb begin
      m_mask     = 8'd1 << m_bsel;
      alu_result = m_opnd;
      if (m_fn == 3'b010) alu_result = m_opnd & ~m_mask;
      else if (m_fn == 3'b100) alu_result = m_opnd | m_mask;
      alu_zero  = (m_fn == 3'b001) ? ((m_opnd & m_mask) == 8'd0) : (alu_result == 8'd0);
      alu_carry = !(force_nc && alu_oe == 2'd3);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic chk_word(input string nm, input logic [2:0] bs, input logic [7:0] op,
                           input logic [1:0] oe, input logic la, input logic lb,
                           input logic [2:0] rsv, input logic [3:0] nclh,
                           input logic busy, input logic ready);
      chk(nm, {6'd0, alu_bs, alu_op, alu_oe, alu_la, alu_lb, alu_sh, alu_r, alu_s, alu_v,
               alu_ne, alu_ci, alu_l, alu_h, alu_busy, bus.req_ready},
              {6'd0, bs, op, oe, la, lb, 2'b00, rsv, nclh, busy, ready});
   endtask

   // scoreboard monitor; resp_valid appears 3 edges after the accept edge (cycle T+4)
   always @(negedge clk) begin
      if (reset_n && bus.resp_valid) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_resp: got resp_valid=1 data=%0h expected no response", bus.resp_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_data", {24'd0, bus.resp_data}, {24'd0, e.d});
            chk("resp_zero", {31'd0, bus.resp_zero}, {31'd0, e.z});
            chk("resp_latency", cyc - e.acc, 32'd3);
         end
      end
   end

   task automatic do_accept(input logic [1:0] op, input logic [2:0] b, input logic [7:0] d,
                            output int acc);
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready) begin
         n_total++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 within 20 cycles");
      end
      bus.req_op = op;
      bus.req_bit = b;
      bus.req_data = d;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] b, input logic [7:0] d,
                        input logic [7:0] ed, input logic ez);
      int acc;
      do_accept(op, b, d, acc);
      bus.req_valid = 1'b0;
      sb.push_back('{ed, ez, acc});
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || !bus.req_ready) && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", sb.size(), 32'd0);
   endtask

   initial begin
      int acc1, acc2, t;
      logic exp_err;
      bus.req_valid = 1'b0;
      bus.req_op = 2'd0;
      bus.req_bit = 3'd0;
      bus.req_data = 8'd0;

      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_resp_data", {24'd0, bus.resp_data}, 32'd0);
      chk("rst_resp_zero", {31'd0, bus.resp_zero}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk_word("rst_word", 3'd0, 8'h00, 2'd0, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);

      // RES a=FF b=3 with per-phase control words
      do_accept(2'd1, 3'd3, 8'hFF, acc1);
      bus.req_valid = 1'b0;
      sb.push_back('{8'hF7, 1'b0, acc1});
      @(negedge clk);
      chk_word("ph0_word", 3'd3, 8'h00, 2'd1, 1'b0, 1'b1, 3'b000, 4'b0000, 1'b1, 1'b0);
      @(negedge clk);
      chk_word("ph1_word", 3'd0, 8'hFF, 2'd2, 1'b1, 1'b0, 3'b010, 4'b1110, 1'b1, 1'b0);
      @(negedge clk);
      chk_word("ph2_word", 3'd0, 8'h00, 2'd3, 1'b0, 1'b0, 3'b010, 4'b1101, 1'b1, 1'b0);
      @(negedge clk);
      chk_word("resp_word", 3'd0, 8'h00, 2'd0, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
      chk("resp_strobe", {31'd0, bus.resp_valid}, 32'd1);
      @(negedge clk);
      chk_word("idle_word", 3'd0, 8'h00, 2'd0, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);
      chk("resp_one_cycle", {31'd0, bus.resp_valid}, 32'd0);
      chk("resp_data_held", {24'd0, bus.resp_data}, 32'hF7);

      issue(2'd1, 3'd3, 8'h08, 8'h00, 1'b1);
      issue(2'd2, 3'd7, 8'h00, 8'h80, 1'b0);
      issue(2'd0, 3'd4, 8'h10, 8'h10, 1'b0);
      issue(2'd0, 3'd0, 8'h10, 8'h10, 1'b1);
      issue(2'd3, 3'd7, 8'h80, 8'h80, 1'b0);
      drain();

      // back-to-back with req_valid held, then ignored pulses while busy
      do_accept(2'd1, 3'd1, 8'h5A, acc1);
      sb.push_back('{8'h58, 1'b0, acc1});
      bus.req_op = 2'd2;
      bus.req_bit = 3'd3;
      bus.req_data = 8'hA5;
      t = 0;
      @(negedge clk);
      while (!bus.req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      acc2 = cyc;
      sb.push_back('{8'hAD, 1'b0, acc2});
      chk("b2b_spacing", acc2 - acc1, 32'd5);
      bus.req_op = 2'd2;
      bus.req_bit = 3'd0;
      bus.req_data = 8'h00;
      @(negedge clk) bus.req_valid = 1'b1;
      @(negedge clk) bus.req_valid = 1'b0;
      @(negedge clk) bus.req_valid = 1'b1;
      @(negedge clk) bus.req_valid = 1'b0;
      drain();

      // reset while in PH1 drops the request
      do_accept(2'd2, 3'd0, 8'h00, acc1);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk_word("midrst_word", 3'd0, 8'h00, 2'd0, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);
      chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("midrst_resp_data", {24'd0, bus.resp_data}, 32'd0);
      repeat (6) @(negedge clk);
      issue(2'd1, 3'd4, 8'hF0, 8'hE0, 1'b0);
      drain();
      chk("err_clean", {31'd0, err}, 32'd0);

      // carry forced low during PH2
`ifdef ALU_SEQ_CARRY_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      force_nc = 1'b1;
      issue(2'd2, 3'd1, 8'h01, 8'h03, 1'b0);
      drain();
      force_nc = 1'b0;
      chk("err_after_nc", {31'd0, err}, {31'd0, exp_err});
      issue(2'd0, 3'd5, 8'h00, 8'h00, 1'b1);
      drain();
      chk("err_sticky", {31'd0, err}, {31'd0, exp_err});
      @(negedge clk) reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("err_after_rst", {31'd0, err}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/alu_bitop_seq.md
# alu_bitop_seq

Micro-sequencer that executes CB-prefix bit instructions (BIT, RES, SET) on the shared ALU. It accepts one request at a time over a valid/ready handshake and drives the ALU control lines through a fixed three-phase sequence: bit select, operand load, result. It then returns the 8-bit result and zero flag, and releases the ALU. It sits between the instruction decoder and the ALU, and owns the ALU only while a bit operation is in flight.

## Interface
- No parameters.
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  reset: **one clock; reset is synchronous and active-low.**
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer idle and able to accept.
- `req_op`  in  2  operation: 0 = BIT, 1 = RES, 2 = SET, 3 = reserved (treated as BIT).
- `req_bit`  in  3  bit index b.
- `req_data`  in  8  operand a.
- `resp_valid`  out  1  one-cycle result strobe.
- `resp_data`  out  8  result, held until the next `resp_valid`.
- `resp_zero`  out  1  zero flag, held alongside `resp_data`.
- `err`  out  1  sticky carry-check error (see Configuration).
- `alu_busy`  out  1  sequencer owns the ALU (PH0..PH2).
- ALU control:
  - `alu_bs`  out  3  bit select.
  - `alu_op`  out  8  operand.
  - `alu_oe`  out  2  bus source: IDLE_OE, BS_OE, SH_OE, RES_OE.
  - `alu_la`, `alu_lb`  out  1 each  load enables: BUS_LD / NO_LD.
  - `alu_sh`  out  shift select: NO_SH while busy.
  - `alu_r`, `alu_s`, `alu_v`, `alu_ne`, `alu_ci`, `alu_l`, `alu_h`  out  1 each  function/carry/nibble controls.
- ALU status:
  - `alu_result`  in  8  ALU result.
  - `alu_zero`  in  1  ALU zero flag.
  - `alu_carry`  in  1  ALU carry flag.

## Operation
- FSM states: IDLE, PH0, PH1, PH2, RESP.
- IDLE:
  - `req_ready`=1; ALU outputs at idle word: oe=IDLE_OE, la=lb=NO_LD, all function bits 0, `alu_bs`/`alu_op`=0.
  - On `req_valid && req_ready`, latch op/bit/data and go to PH0.
- PH0: `alu_bs`=b, oe=BS_OE, lb=BUS_LD, la=NO_LD.
- PH1:
  - Common fields: `alu_op`=a, sh=NO_SH, oe=SH_OE, la=BUS_LD, lb=NO_LD, ne=1, ci=1, l=1, h=0.
  - RES: r=0, s=1, v=0.
  - SET: r=1, s=0, v=0.
  - BIT: r=0, s=0, v=1.
- PH2:
  - Common fields: la=lb=NO_LD, oe=RES_OE, ne=1, ci=1, l=0, h=1; r/s/v as in PH1.
  - Capture `alu_result` into `resp_data` and `alu_zero` into `resp_zero`.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE.
- Expected results:
  - RES → a & ~(1<<b), zero = (result==0).
  - SET → a | (1<<b), zero = (result==0).
  - BIT → `resp_data`=a unchanged; zero = !a[b].
  - b wraps naturally within 3 bits.
- `req_valid` outside IDLE is ignored: no queuing, and the request must be held until accepted.
- Reset (any state, including mid-sequence):
  - Next cycle is IDLE; `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_zero`=0, `err`=0, `alu_busy`=0.
  - ALU outputs return to the idle word; any in-flight request is dropped with no response.

## Timing
- Accept edge at cycle T.
- ALU phases: PH0 at T+1, PH1 at T+2, PH2 at T+3; `resp_valid` at T+4; next accept earliest at T+5.
- Throughput: one operation per 5 cycles.
- `req_ready` is registered, and is 0 from T+1 through T+4.
- `alu_busy`=1 exactly during PH0..PH2.
- All ALU outputs are registered from state, with no combinational path from `req_*`.
- `alu_result`/`alu_zero` are sampled only at the end of PH2.

## Configuration
- `ALU_SEQ_CARRY_CHECK_EN` defined:
  - At the end of PH1 and PH2, if `alu_carry`==0, `err` is set.
  - `err` stays set until reset.
- Undefined: `err` is tied to 0 and no check logic is built.
- Sequencing is identical either way.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles → `req_ready`=1, `resp_valid`=0, `resp_data`=0x00, `err`=0, ALU at idle word.
- RES, a=0xFF, b=3 → PH0/PH1/PH2 control words exact per cycle; `resp_valid` at T+4 with 0xF7, zero=0. Then a=0x08, b=3 → 0x00, zero=1.
- SET, a=0x00, b=7 → 0x80, zero=0; BIT, a=0x10, b=4 → data 0x10, zero=0; BIT, a=0x10, b=0 → zero=1.
- Back-to-back requests with `req_valid` held high → second accept exactly at T+5; `req_valid` pulses during busy cycles are ignored with no extra response.
- Reset asserted in PH1 → IDLE next cycle, no `resp_valid`, ALU outputs idle; a new request then completes normally.
- With `ALU_SEQ_CARRY_CHECK_EN`: force `alu_carry`=0 in PH2 → `err`=1 from the next cycle until reset. Without the macro: `err` stays 0.
